// File: rtl/div_subshift_multi.sv
// ============================================================================
// Module   : div_subshift_multi
// Brief    : Iterative restoring divider, signed/unsigned, STEPS quotient bits
//            per cycle, valid/ready in and out.
//            Optional macro DIV_SUBSHIFT_MULTI_EARLY_EXIT_EN skips iteration
//            when the quotient magnitude is trivially zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_subshift_multi #(
    parameter int DATA_W = 32,
    parameter int STEPS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int c_ITERS = DATA_W / STEPS;
    localparam int c_CNT_W = $clog2(c_ITERS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITERS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    // r_dq starts as the dividend magnitude and fills with quotient bits from the LSB
    logic [DATA_W-1:0]  r_dq;
    logic [DATA_W-1:0]  r_prem;
    logic [DATA_W-1:0]  r_dvs_mag;
    logic [DATA_W-1:0]  r_dvd_raw;
    logic               r_dvd_neg;
    logic               r_dvs_neg;
    logic               r_dbz;
    logic [DATA_W-1:0]  r_quotient;
    logic [DATA_W-1:0]  r_remainder;
    logic               r_div_by_zero;

    logic [DATA_W-1:0]  w_dvd_mag;
    logic [DATA_W-1:0]  w_dvs_mag;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic               w_dbz;

    logic [STEPS:0][DATA_W-1:0] w_rem;
    logic [STEPS:0][DATA_W-1:0] w_q;

    always_comb begin
        w_dvd_neg = sign & dividend[DATA_W-1];
        w_dvs_neg = sign & divisor[DATA_W-1];
        w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
        w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;
        w_dbz     = (divisor == '0);
    end

    assign w_rem[0] = r_prem;
    assign w_q[0]   = r_dq;

    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_step
            logic [DATA_W:0]   w_shift;
            logic [DATA_W-1:0] w_diff;
            logic              w_ge;
            // Compare at DATA_W+1 bits; when w_ge the true difference fits DATA_W bits
            assign w_shift = {w_rem[gi], w_q[gi][DATA_W-1]};
            assign w_ge    = (w_shift >= {1'b0, r_dvs_mag});
            assign w_diff  = w_shift[DATA_W-1:0] - r_dvs_mag;
            assign w_rem[gi+1] = w_ge ? w_diff : w_shift[DATA_W-1:0];
            assign w_q[gi+1]   = {w_q[gi][DATA_W-2:0], w_ge};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_dq          <= '0;
            r_prem        <= '0;
            r_dvs_mag     <= '0;
            r_dvd_raw     <= '0;
            r_dvd_neg     <= 1'b0;
            r_dvs_neg     <= 1'b0;
            r_dbz         <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_dvs_mag <= w_dvs_mag;
                        r_dvd_raw <= dividend;
                        r_dvd_neg <= w_dvd_neg;
                        r_dvs_neg <= w_dvs_neg;
                        r_dbz     <= w_dbz;
                        r_cnt     <= '0;
`ifdef DIV_SUBSHIFT_MULTI_EARLY_EXIT_EN
                        if (w_dbz || (w_dvd_mag < w_dvs_mag)) begin
                            r_dq    <= '0;
                            r_prem  <= w_dvd_mag;
                            r_state <= c_FIX;
                        end else begin
                            r_dq    <= w_dvd_mag;
                            r_prem  <= '0;
                            r_state <= c_ITER;
                        end
`else
                        r_dq    <= w_dvd_mag;
                        r_prem  <= '0;
                        r_state <= c_ITER;
`endif
                    end
                end
                c_ITER: begin
                    r_prem <= w_rem[STEPS];
                    r_dq   <= w_q[STEPS];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    if (r_dbz) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_dvd_raw;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        // Overflow case (-2^(W-1) / -1) wraps to the required pattern
                        r_quotient    <= (r_dvd_neg ^ r_dvs_neg) ? (~r_dq + 1'b1) : r_dq;
                        r_remainder   <= r_dvd_neg ? (~r_prem + 1'b1) : r_prem;
                        r_div_by_zero <= 1'b0;
                    end
                    r_state <= c_OUT;
                end
                c_OUT: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == c_IDLE);
    assign out_valid   = (r_state == c_OUT);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_div_subshift_multi.sv
// ============================================================================
// Module   : tb_div_subshift_multi
// Brief    : Directed and random checks of div_subshift_multi, STEPS=1 and 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_subshift_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        sign      [2];
    logic        out_ready [2];
    logic [31:0] dvd       [2];
    logic [31:0] dvs       [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] quo       [2];
    logic [31:0] rem       [2];
    logic        dbz       [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_subshift_multi #(.DATA_W(32), .STEPS(1)) u_s1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sign(sign[0]),
        .dividend(dvd[0]), .divisor(dvs[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .quotient(quo[0]), .remainder(rem[0]), .div_by_zero(dbz[0])
    );

    div_subshift_multi #(.DATA_W(32), .STEPS(4)) u_s4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sign(sign[1]),
        .dividend(dvd[1]), .divisor(dvs[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .quotient(quo[1]), .remainder(rem[1]), .div_by_zero(dbz[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference semantics: truncating division, remainder takes dividend sign
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint unsigned ma, mb, qm, rm;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1'b1;
        end else begin
            z  = 1'b0;
            ma = (s && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
            mb = (s && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
            qm = ma / mb;
            rm = ma % mb;
            q  = (s && (a[31] ^ b[31])) ? (32'd0 - qm[31:0]) : qm[31:0];
            r  = (s && a[31]) ? (32'd0 - rm[31:0]) : rm[31:0];
        end
    endtask

    task automatic wait_ready(input string tag, input int d);
        int w = 0;
        while (in_ready[d] !== 1'b1 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) check({tag, "_ready_timeout"}, {31'd0, in_ready[d]}, 32'd1);
    endtask

    task automatic op(input string tag, input int d, input logic s,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic ez,
                      input int elat, input int hold);
        int lat;
        wait_ready(tag, d);
        sign[d] = s; dvd[d] = a; dvs[d] = b; in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0; dvd[d] = 32'hDEAD_BEEF; dvs[d] = 32'h0BAD_F00D; sign[d] = ~s;
        lat = 1;
        while (out_valid[d] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_valid"}, {31'd0, out_valid[d]}, 32'd1);
        check({tag, "_quo"}, quo[d], eq);
        check({tag, "_rem"}, rem[d], er);
        check({tag, "_dbz"}, {31'd0, dbz[d]}, {31'd0, ez});
        if (elat > 0) check({tag, "_lat"}, 32'(lat), 32'(elat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'd0, out_valid[d]}, 32'd1);
            check({tag, "_hold_inrdy"}, {31'd0, in_ready[d]}, 32'd0);
            check({tag, "_hold_quo"}, quo[d], eq);
            check({tag, "_hold_rem"}, rem[d], er);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check({tag, "_done_inrdy"}, {31'd0, in_ready[d]}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        rs, ez;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; sign[d] = 1'b0; out_ready[d] = 1'b0;
            dvd[d] = 32'd0; dvs[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_inrdy", {31'd0, in_ready[0]}, 32'd1);
        check("rst_outv",  {31'd0, out_valid[0]}, 32'd0);
        check("rst_quo",   quo[0], 32'd0);
        check("rst_rem",   rem[0], 32'd0);
        check("rst_dbz",   {31'd0, dbz[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // STEPS=1 directed
        op("u100_7",   0, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34, 0);
        op("s-100_7",  0, 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 0);
        op("s100_-7",  0, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 34, 0);
        op("dbz",      0, 1'b1, 32'h8000_0005, 32'd0,         32'hFFFF_FFFF, 32'h8000_0005, 1'b1, -1, 0);
        op("s_ovf",    0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 34, 0);
        op("u_ovf",    0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34, 0);
        op("u_big",    0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 34, 0);

        // STEPS=4 directed, with output back-pressure
        op("s4_ff_3",  1, 1'b0, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 32'd0,         1'b0, 10, 5);
        op("s4_s_neg", 1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 10, 0);

        // STEPS=4 back-to-back random operations
        for (int i = 0; i < 12; i++) begin
            ra = $urandom();
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 17)) : $urandom() >> $urandom_range(0, 31);
            if (i % 4 == 1) rb = -rb;
            rs = 1'($urandom_range(0, 1));
            model(rs, ra, rb, eq, er, ez);
            op($sformatf("rnd%0d", i), 1, rs, ra, rb, eq, er, ez, -1, 0);
        end

        // Reset while iterating aborts the operation
        wait_ready("abort", 0);
        sign[0] = 1'b0; dvd[0] = 32'd1000; dvs[0] = 32'd3; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, in_ready[0]}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_inrdy", {31'd0, in_ready[0]}, 32'd1);
        check("abort_outv",  {31'd0, out_valid[0]}, 32'd0);
        check("abort_quo",   quo[0], 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_out", {31'd0, out_valid[0]}, 32'd0);
        op("post_9_2", 0, 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 34, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
